// File: rtl/lane_pkg.sv
// Shared types and helpers for the vector-lane pipeline blocks
// (parallel register stage and lane_serializer).
package lane_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic ready;
  } handshake_t;

  // Lane index width, at least one bit so DEPTH=1 still has a usable index.
  function automatic int lane_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lane_next_active.sv
// Priority encoder over a lane mask: first set lane, highest set lane,
// and next set lane strictly above the current index.
module lane_next_active #(
  parameter int DEPTH  = 4,
  parameter int LANE_W = 2
) (
  input  logic [DEPTH-1:0]  mask,
  input  logic [LANE_W-1:0] idx,
  output logic [LANE_W-1:0] next_lane,
  output logic [LANE_W-1:0] first_lane,
  output logic [LANE_W-1:0] last_lane,
  output logic              any_set
);

  // Downward scans let the lowest qualifying lane win for first/next.
  always_comb begin
    next_lane  = '0;
    first_lane = '0;
    last_lane  = '0;
    any_set    = |mask;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (mask[j]) begin
        first_lane = LANE_W'(j);
      end
      if (mask[j] && (j > int'(idx))) begin
        next_lane = LANE_W'(j);
      end
    end
    for (int j = 0; j < DEPTH; j++) begin
      if (mask[j]) begin
        last_lane = LANE_W'(j);
      end
    end
  end

endmodule

// File: rtl/lane_serializer.sv
// Accepts one DEPTH-lane vector per beat and emits its lanes one per cycle.
// Define LANE_SERIALIZER_MASK_SKIP_EN to skip lanes whose in_mask bit is 0.
module lane_serializer
  import lane_pkg::*;
#(
  parameter  int WIDTH  = 64,
  parameter  int DEPTH  = 4,
  localparam int LANE_W = lane_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data [DEPTH-1:0],
  input  logic [DEPTH-1:0]  in_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [LANE_W-1:0] out_lane,
  output logic              out_last,
  output logic              busy
);

  state_t            state;
  logic [LANE_W-1:0] idx;
  logic [WIDTH-1:0]  buffer [DEPTH-1:0];
  logic [LANE_W-1:0] last_lane;
  logic [LANE_W-1:0] first_lane;
  logic [LANE_W-1:0] next_lane;
  logic              capture_last;
  logic              capture_any;
  logic              accept;
  logic              advance;
  logic              finish;

`ifdef LANE_SERIALIZER_MASK_SKIP_EN
  logic [DEPTH-1:0]  mask_q;
  logic [LANE_W-1:0] last_q;
  logic [LANE_W-1:0] in_next_unused;
  logic [LANE_W-1:0] q_first_unused;
  logic [LANE_W-1:0] q_last_unused;
  logic              q_any_unused;
  logic              unused_enc;

  // Encoder on the incoming mask picks the start lane and final lane at capture.
  lane_next_active #(.DEPTH(DEPTH), .LANE_W(LANE_W)) u_in_enc (
    .mask       (in_mask),
    .idx        ('0),
    .next_lane  (in_next_unused),
    .first_lane (first_lane),
    .last_lane  (capture_last),
    .any_set    (capture_any)
  );

  lane_next_active #(.DEPTH(DEPTH), .LANE_W(LANE_W)) u_held_enc (
    .mask       (mask_q),
    .idx        (idx),
    .next_lane  (next_lane),
    .first_lane (q_first_unused),
    .last_lane  (q_last_unused),
    .any_set    (q_any_unused)
  );

  assign unused_enc = ^{in_next_unused, q_first_unused, q_last_unused, q_any_unused};
  assign last_lane  = last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '1;
      last_q <= LANE_W'(DEPTH - 1);
    end else if (accept) begin
      mask_q <= in_mask;
      last_q <= capture_last;
    end
  end
`else
  logic unused_mask;

  assign unused_mask  = ^in_mask;
  assign first_lane   = '0;
  assign next_lane    = idx + LANE_W'(1);
  assign last_lane    = LANE_W'(DEPTH - 1);
  assign capture_last = 1'b1;
  assign capture_any  = 1'b1;
`endif

  assign busy      = (state == SHIFT);
  assign out_valid = busy;
  assign out_lane  = idx;
  assign out_last  = busy && (idx == last_lane);
  assign in_ready  = (state == IDLE) || (out_valid && out_ready && out_last);
  assign accept    = in_valid && in_ready;
  assign advance   = out_valid && out_ready && !out_last;
  assign finish    = out_valid && out_ready && out_last;

  always_comb begin
    out_data = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (idx == LANE_W'(j)) begin
        out_data = buffer[j];
      end
    end
  end

  // Capture has priority so a vector offered during the final beat follows with no bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        buffer[j] <= '0;
      end
    end else if (accept) begin
      buffer <= in_data;
      idx    <= first_lane;
      state  <= capture_any ? SHIFT : IDLE;
    end else if (advance) begin
      idx <= next_lane;
    end else if (finish) begin
      state <= IDLE;
    end
  end

endmodule
